// File: rtl/bw_sel_nr_dw_gen.sv
// NR bandwidth selector: per-frame mode capture, antenna strobe generation and
// path-0 interleaving of a delayed path 1 in reduced-bandwidth modes.
module bw_sel_nr_dw_gen #(
  parameter int DATA_W    = 32,
  parameter int NUM_PATH  = 2,
  parameter int BUF_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   i_bw_sel,
  input  logic [NUM_PATH-1:0]          i_fram,
  input  logic [NUM_PATH-1:0]          i_xant,
  input  logic [NUM_PATH*DATA_W-1:0]   i_data,
  output logic [NUM_PATH-1:0]          o_fram,
  output logic [NUM_PATH-1:0]          o_xant,
  output logic [NUM_PATH*DATA_W-1:0]   o_data,
  output logic [2:0]                   o_sel_active,
  output logic                         o_sel_err
);

  typedef enum logic [2:0] {
    BW_7M68   = 3'd0,
    BW_15M36  = 3'd1,
    BW_30M72  = 3'd2,
    BW_61M44  = 3'd3,
    BW_122M88 = 3'd4
  } bw_mode_e;

  localparam bit HAS_DL = (NUM_PATH >= 2);

  bw_mode_e                   sel_act;
  bw_mode_e                   sel_next;
  logic [5:0]                 cnt;
  logic                       boundary;
  logic                       bw_legal;
  logic [5:0]                 strobe_mask;
  logic                       strobe;
  logic [DATA_W-1:0]          tail;
  logic [NUM_PATH-1:0]        fram_d;
  logic [NUM_PATH-1:0]        xant_d;
  logic [NUM_PATH*DATA_W-1:0] data_d;

  assign boundary     = &i_fram;
  assign bw_legal     = (i_bw_sel <= 3'd4);
  assign o_sel_active = sel_act;

  // Strobe fires when the low (6 - mode) bits of cnt are all ones.
  assign strobe_mask = 6'h3f >> sel_act;
  assign strobe      = ((cnt & strobe_mask) == strobe_mask);

  generate
    if (HAS_DL) begin : g_dl
      logic [DATA_W-1:0] dl [BUF_DEPTH];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < BUF_DEPTH; i++) dl[i] <= '0;
        end else begin
          dl[0] <= i_data[DATA_W +: DATA_W];
          for (int i = 1; i < BUF_DEPTH; i++) dl[i] <= dl[i-1];
        end
      end
      assign tail = dl[BUF_DEPTH-1];
    end else begin : g_no_dl
      assign tail = '0;
    end
  endgenerate

  always_comb begin
    sel_next = sel_act;
    if (boundary) sel_next = bw_legal ? bw_mode_e'(i_bw_sel) : BW_122M88;
  end

  // Outputs are computed from the mode in force this cycle, so a boundary
  // cycle still uses the old mode and the new one starts cleanly next cycle.
  always_comb begin
    fram_d = '0;
    xant_d = '0;
    data_d = '0;
    if (sel_act == BW_122M88) begin
      fram_d = i_fram;
      xant_d = i_xant;
      data_d = i_data;
    end else begin
      fram_d[0]           = i_fram[0];
      xant_d[0]           = strobe;
      data_d[DATA_W-1:0]  = (HAS_DL && cnt[2]) ? tail : i_data[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_act   <= BW_122M88;
      cnt       <= '0;
      o_fram    <= '0;
      o_xant    <= '0;
      o_data    <= '0;
      o_sel_err <= 1'b0;
    end else begin
      sel_act   <= sel_next;
      cnt       <= boundary ? 6'd0 : cnt + 6'd1;
      o_fram    <= fram_d;
      o_xant    <= xant_d;
      o_data    <= data_d;
      o_sel_err <= boundary && !bw_legal;
    end
  end

endmodule

// File: tb/tb_bw_sel_nr_dw_gen.sv
// Bench for bw_sel_nr_dw_gen: three parameterisations share one stimulus
// stream and are checked every cycle against a cycle-history reference model.
module tb_bw_sel_nr_dw_gen;

  logic        clk;
  logic        rst;
  logic [2:0]  bw;
  logic [3:0]  fram;
  logic [3:0]  xant;
  logic [63:0] lane [4];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  // dut0: NUM_PATH=2 DATA_W=32 BUF_DEPTH=4
  logic [1:0]   o_fram0, o_xant0;
  logic [63:0]  o_data0;
  logic [2:0]   sel0;
  logic         err0;
  // dut1: NUM_PATH=1 DATA_W=16 BUF_DEPTH=1
  logic [0:0]   o_fram1, o_xant1;
  logic [15:0]  o_data1;
  logic [2:0]   sel1;
  logic         err1;
  // dut2: NUM_PATH=4 DATA_W=64 BUF_DEPTH=8
  logic [3:0]   o_fram2, o_xant2;
  logic [255:0] o_data2;
  logic [2:0]   sel2;
  logic         err2;

  bw_sel_nr_dw_gen #(.DATA_W(32), .NUM_PATH(2), .BUF_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .i_bw_sel(bw), .i_fram(fram[1:0]), .i_xant(xant[1:0]),
    .i_data({lane[1][31:0], lane[0][31:0]}),
    .o_fram(o_fram0), .o_xant(o_xant0), .o_data(o_data0),
    .o_sel_active(sel0), .o_sel_err(err0));

  bw_sel_nr_dw_gen #(.DATA_W(16), .NUM_PATH(1), .BUF_DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .i_bw_sel(bw), .i_fram(fram[0:0]), .i_xant(xant[0:0]),
    .i_data(lane[0][15:0]),
    .o_fram(o_fram1), .o_xant(o_xant1), .o_data(o_data1),
    .o_sel_active(sel1), .o_sel_err(err1));

  bw_sel_nr_dw_gen #(.DATA_W(64), .NUM_PATH(4), .BUF_DEPTH(8)) dut2 (
    .clk(clk), .rst(rst), .i_bw_sel(bw), .i_fram(fram), .i_xant(xant),
    .i_data({lane[3], lane[2], lane[1], lane[0]}),
    .o_fram(o_fram2), .o_xant(o_xant2), .o_data(o_data2),
    .o_sel_active(sel2), .o_sel_err(err2));

  logic [3:0]   act_f [3];
  logic [3:0]   act_x [3];
  logic [255:0] act_d [3];
  logic [2:0]   act_s [3];
  logic         act_e [3];

  assign act_f[0] = 4'(o_fram0);  assign act_x[0] = 4'(o_xant0);
  assign act_d[0] = 256'(o_data0); assign act_s[0] = sel0; assign act_e[0] = err0;
  assign act_f[1] = 4'(o_fram1);  assign act_x[1] = 4'(o_xant1);
  assign act_d[1] = 256'(o_data1); assign act_s[1] = sel1; assign act_e[1] = err1;
  assign act_f[2] = o_fram2;      assign act_x[2] = o_xant2;
  assign act_d[2] = o_data2;      assign act_s[2] = sel2; assign act_e[2] = err2;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic int np_of(input int k);
    case (k) 0: return 2; 1: return 1; default: return 4; endcase
  endfunction
  function automatic int dw_of(input int k);
    case (k) 0: return 32; 1: return 16; default: return 64; endcase
  endfunction
  function automatic int bd_of(input int k);
    case (k) 0: return 4; 1: return 1; default: return 8; endcase
  endfunction

  int           m_sel [3];
  int           m_age [3];            // cycles since the last boundary, mod 64
  logic [63:0]  hist  [3][8];         // hist[k][j] = path 1 sample from j+1 cycles ago
  logic [3:0]   exp_f [3];
  logic [3:0]   exp_x [3];
  logic [255:0] exp_d [3];
  logic [2:0]   exp_s [3];
  logic         exp_e [3];

  task automatic model_step(input int k);
    int np, dw, bd, period;
    logic [3:0]  npmask;
    logic [63:0] dmask;
    bit bnd;
    np = np_of(k); dw = dw_of(k); bd = bd_of(k);
    npmask = 4'((1 << np) - 1);
    dmask  = (dw == 64) ? '1 : ((64'd1 << dw) - 64'd1);
    bnd    = ((fram & npmask) == npmask);
    exp_f[k] = '0; exp_x[k] = '0; exp_d[k] = '0; exp_e[k] = 1'b0;
    if (rst) begin
      m_sel[k] = 4;
      m_age[k] = 0;
      for (int j = 0; j < 8; j++) hist[k][j] = '0;
    end else begin
      if (m_sel[k] == 4) begin
        for (int p = 0; p < np; p++) begin
          exp_f[k][p] = fram[p];
          exp_x[k][p] = xant[p];
          exp_d[k]    = exp_d[k] | (256'(lane[p] & dmask) << (p * dw));
        end
      end else begin
        period      = 64 / (1 << m_sel[k]);
        exp_f[k][0] = fram[0];
        exp_x[k][0] = (m_age[k] % period) == (period - 1);
        if (np >= 2 && ((m_age[k] / 4) % 2) == 1)
          exp_d[k] = 256'(hist[k][bd-1]);
        else
          exp_d[k] = 256'(lane[0] & dmask);
      end
      exp_e[k] = bnd && (bw > 3'd4);
      for (int j = 7; j > 0; j--) hist[k][j] = hist[k][j-1];
      hist[k][0] = lane[1] & dmask;
      if (bnd) begin
        m_sel[k] = (bw > 3'd4) ? 4 : int'(bw);
        m_age[k] = 0;
      end else begin
        m_age[k] = (m_age[k] + 1) % 64;
      end
    end
    exp_s[k] = 3'(m_sel[k]);
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int k, input logic [255:0] act,
                       input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        check("o_fram", k, 256'(act_f[k]), 256'(exp_f[k]));
        check("o_xant", k, 256'(act_x[k]), 256'(exp_x[k]));
        check("o_data", k, act_d[k], exp_d[k]);
        check("o_sel_active", k, 256'(act_s[k]), 256'(exp_s[k]));
        check("o_sel_err", k, 256'(act_e[k]), 256'(exp_e[k]));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    fram = '0; xant = '0; bw = '0;
    for (int p = 0; p < 4; p++) lane[p] = '0;
  endtask

  initial begin
    int first, count;
    rst = 1'b1;
    drive_idle();
    step();
    chk_en = 1;
    step();
    check("reset_sel", 0, 256'(sel0), 256'(3'd4));
    check("reset_data", 0, 256'(o_data0), 256'(0));
    check("reset_err", 0, 256'(err0), 256'(0));
    rst = 1'b0;

    // Mode 0 from a single boundary, then no frame strobes.
    fram = 4'hF; bw = 3'd0;
    step();
    fram = 4'h0;
    first = -1; count = 0;
    for (int n = 1; n <= 200; n++) begin
      step();
      if (o_xant0[0]) begin
        count++;
        if (first < 0) first = n;
      end
    end
    check("m0_sel", 0, 256'(sel0), 256'(3'd0));
    check("m0_first_pulse", 0, 256'(first), 256'(64));
    check("m0_pulse_count", 0, 256'(count), 256'(3));
    check("m0_fram1", 0, 256'(o_fram0[1]), 256'(0));

    // Mode 3 interleave of path 0 and path 1 delayed by four.
    lane[0] = 64'hAAAA0000; lane[1] = 64'hBBBB0000;
    fram = 4'hF; bw = 3'd3;
    step();
    fram = 4'h0;
    for (int n = 1; n <= 24; n++) begin
      lane[0] = 64'hAAAA0000 + 64'(n);
      lane[1] = 64'hBBBB0000 + 64'(n);
      step();
      if (n == 2) check("m3_path0", 0, 256'(o_data0[31:0]), 256'(32'hAAAA0002));
      if (n == 6) check("m3_delayed", 0, 256'(o_data0[31:0]), 256'(32'hBBBB0002));
      if (n == 7) check("m3_path1_zero", 0, 256'(o_data0[63:32]), 256'(0));
      if (n == 8) check("m3_strobe", 0, 256'(o_xant0[0]), 256'(1));
      if (n == 9) check("m3_no_strobe", 0, 256'(o_xant0[0]), 256'(0));
    end

    // Mode 4, request for mode 2 arrives mid-frame.
    fram = 4'hF; bw = 3'd4;
    step();
    fram = 4'h0; bw = 3'd2; xant = 4'hF; lane[1] = 64'h5555_6666_7777_8888;
    repeat (5) step();
    check("mid_sel_hold", 0, 256'(sel0), 256'(3'd4));
    check("mid_xant_pass", 0, 256'(o_xant0), 256'(2'b11));
    fram = 4'hF;
    step();
    check("bnd_sel_new", 0, 256'(sel0), 256'(3'd2));
    check("bnd_fram_old_mode", 0, 256'(o_fram0), 256'(2'b11));
    fram = 4'h0;
    step();
    check("m2_fram1", 0, 256'(o_fram0[1]), 256'(0));
    check("m2_xant1", 0, 256'(o_xant0[1]), 256'(0));
    check("m2_data1", 0, 256'(o_data0[63:32]), 256'(0));

    // Illegal selection while in passthrough.
    fram = 4'hF; bw = 3'd4;
    step();
    bw = 3'd6;
    step();
    check("illegal_err", 0, 256'(err0), 256'(1));
    check("illegal_sel", 0, 256'(sel0), 256'(3'd4));
    fram = 4'h0; lane[1] = 64'h1234_5678_9ABC_DEF0;
    step();
    check("illegal_err_clear", 0, 256'(err0), 256'(0));
    check("illegal_pass", 0, 256'(o_data0[63:32]), 256'(32'h9ABCDEF0));

    // Reset coinciding with a boundary.
    rst = 1'b1; fram = 4'hF; bw = 3'd1; xant = 4'hF;
    step();
    check("rst_bnd_sel", 0, 256'(sel0), 256'(3'd4));
    check("rst_bnd_fram", 0, 256'(o_fram0), 256'(0));
    check("rst_bnd_xant", 0, 256'(o_xant0), 256'(0));
    check("rst_bnd_data", 0, 256'(o_data0), 256'(0));
    rst = 1'b0; fram = 4'h0; xant = 4'h0;
    step();
    check("rst_release_sel", 0, 256'(sel0), 256'(3'd4));

    // Wide passthrough and narrow single-path mode 0.
    fram = 4'hF; bw = 3'd4;
    step();
    fram = 4'h0; lane[3] = 64'hFEDC_BA98_7654_3210;
    step();
    check("np4_lane3", 2, o_data2[255:192], 256'(64'hFEDC_BA98_7654_3210));
    fram = 4'h1; bw = 3'd0;
    step();
    fram = 4'h0; lane[0] = 64'h0000_0000_0000_CAFE;
    step();
    check("np1_m0_data", 1, 256'(o_data1), 256'(16'hCAFE));

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 199) == 0);
      fram = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom);
      bw   = 3'($urandom);
      xant = 4'($urandom);
      for (int p = 0; p < 4; p++) lane[p] = {$urandom, $urandom};
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
